// File: rtl/ram_arbiter.sv
// Two-port arbiter for one single-port sync RAM; round-robin, or fixed A-priority with RAM_ARB_FIXED_PRIO_EN.
// Latency: grant is combinational with req; read data returns 2 cycles after the grant, one response per cycle.
// Backpressure: a requester holds req and its inputs until gnt; the response path cannot be stalled.
module ram_arbiter #(
    parameter int AW = 10,
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    logic          gnt_a, gnt_b, any_gnt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          s1_vld_q, s1_vld_d;
    logic          s1_port_q, s1_port_d;
    logic          a_rvalid_q, b_rvalid_q;
    logic [DW-1:0] a_rdata_q, b_rdata_q;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign gnt_a = rst_n & a_req;
    assign gnt_b = rst_n & b_req & ~a_req;
`else
    logic last_grant_q, last_grant_d;

    // On contention the port that did not win last time gets the slot.
    assign gnt_a = rst_n & a_req & (~b_req | (last_grant_q == PORT_B));
    assign gnt_b = rst_n & b_req & ~gnt_a;
    assign last_grant_d = gnt_b ? PORT_B : PORT_A;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= PORT_B;
        end else if (any_gnt) begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign any_gnt = gnt_a | gnt_b;
    assign a_gnt   = gnt_a;
    assign b_gnt   = gnt_b;

    // Idle cycles re-present the last granted address with we=0.
    assign ram_we    = gnt_a ? a_we    : (gnt_b ? b_we    : 1'b0);
    assign ram_addr  = gnt_a ? a_addr  : (gnt_b ? b_addr  : addr_q);
    assign ram_wdata = gnt_a ? a_wdata : (gnt_b ? b_wdata : wdata_q);

    assign s1_vld_d  = any_gnt & ~ram_we;
    assign s1_port_d = gnt_b ? PORT_B : PORT_A;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            s1_vld_q   <= 1'b0;
            s1_port_q  <= PORT_A;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            if (any_gnt) begin
                addr_q  <= ram_addr;
                wdata_q <= ram_wdata;
            end
            s1_vld_q   <= s1_vld_d;
            s1_port_q  <= s1_port_d;
            a_rvalid_q <= s1_vld_q & (s1_port_q == PORT_A);
            b_rvalid_q <= s1_vld_q & (s1_port_q == PORT_B);
            // ram_rdata is valid in the cycle after the read grant; capture it then.
            if (s1_vld_q && s1_port_q == PORT_A) begin
                a_rdata_q <= ram_rdata;
            end
            if (s1_vld_q && s1_port_q == PORT_B) begin
                b_rdata_q <= ram_rdata;
            end
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, queue-based reference model checked every cycle, directed + random stimulus.
module tb_ram_arbiter;
    localparam int AW = 10;
    localparam int DW = 10;
`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr, ram_addr;
    logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_wdata, ram_rdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM: registered read address, combinational read data.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] raddr_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else        raddr_q <= ram_addr;
    end
    assign ram_rdata = mem[raddr_q];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk10(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: shadow memory, last winner, held bus values, queue of due responses.
    typedef struct packed {
        int            due;
        logic          port;
        logic [DW-1:0] data;
    } resp_t;

    resp_t         rq[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic          m_last;
    logic [AW-1:0] m_haddr;
    logic [DW-1:0] m_hwdata, m_rd_a, m_rd_b;

    initial begin
        logic          ea, eb, va, vb, wwe;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wwd;
        resp_t         r;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                rq.delete();
                m_last = 1'b1; m_haddr = '0; m_hwdata = '0; m_rd_a = '0; m_rd_b = '0;
                chk1("rst_a_gnt", a_gnt, 1'b0);
                chk1("rst_b_gnt", b_gnt, 1'b0);
                chk1("rst_ram_we", ram_we, 1'b0);
                chk10("rst_ram_addr", ram_addr, 10'h000);
                chk10("rst_ram_wdata", ram_wdata, 10'h000);
                chk1("rst_a_rvalid", a_rvalid, 1'b0);
                chk1("rst_b_rvalid", b_rvalid, 1'b0);
                chk10("rst_a_rdata", a_rdata, 10'h000);
                chk10("rst_b_rdata", b_rdata, 10'h000);
            end else begin
                if (FIXED) begin
                    ea = a_req;
                end else begin
                    ea = a_req && (!b_req || m_last);
                end
                eb = b_req && !ea;
                chk1("a_gnt", a_gnt, ea);
                chk1("b_gnt", b_gnt, eb);
                wwe   = ea ? a_we : (eb ? b_we : 1'b0);
                waddr = ea ? a_addr : (eb ? b_addr : m_haddr);
                wwd   = ea ? a_wdata : (eb ? b_wdata : m_hwdata);
                chk1("ram_we", ram_we, wwe);
                chk10("ram_addr", ram_addr, waddr);
                chk10("ram_wdata", ram_wdata, wwd);
                va = 1'b0; vb = 1'b0;
                while (rq.size() > 0 && rq[0].due == cyc) begin
                    r = rq.pop_front();
                    if (r.port) begin vb = 1'b1; m_rd_b = r.data; end
                    else        begin va = 1'b1; m_rd_a = r.data; end
                end
                chk1("a_rvalid", a_rvalid, va);
                chk1("b_rvalid", b_rvalid, vb);
                chk10("a_rdata", a_rdata, m_rd_a);
                chk10("b_rdata", b_rdata, m_rd_b);
                if (ea || eb) begin
                    if (wwe) ref_mem[waddr] = wwd;
                    else     rq.push_back('{cyc + 2, eb, ref_mem[waddr]});
                    m_last = eb; m_haddr = waddr; m_hwdata = wwd;
                end
            end
        end
    end

    task automatic set_a(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom);
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        logic ga, gb;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        raddr_q = '0;
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk10("pin_reset_a_rdata", a_rdata, 10'h000);
        chk1("pin_reset_a_gnt", a_gnt, 1'b0);
        next_cycle();
        rst_n = 1'b1;

        // A writes 1,2,3 to addresses 0,1,2 on consecutive cycles.
        for (int i = 0; i < 3; i++) begin
            set_a(1'b1, 1'b1, AW'(i), DW'(i + 1));
            @(negedge clk);
            chk1("pin_wr_gnt", a_gnt, 1'b1);
            chk1("pin_wr_we", ram_we, 1'b1);
            chk1("pin_wr_norv", a_rvalid, 1'b0);
            next_cycle();
        end

        // Back-to-back reads of 0,1,2: responses on three consecutive cycles.
        for (int i = 0; i < 3; i++) begin
            set_a(1'b1, 1'b0, AW'(i), '0);
            @(negedge clk);
            if (i == 2) begin
                chk1("pin_rd0_v", a_rvalid, 1'b1);
                chk10("pin_rd0_d", a_rdata, 10'h001);
            end
            next_cycle();
        end
        set_a(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk1("pin_rd1_v", a_rvalid, 1'b1);
        chk10("pin_rd1_d", a_rdata, 10'h002);
        next_cycle();
        @(negedge clk);
        chk10("pin_rd2_d", a_rdata, 10'h003);
        next_cycle();
        @(negedge clk);
        chk1("pin_rd_end", a_rvalid, 1'b0);
        next_cycle();

        // A single B read makes B the last winner, so A takes the next tie.
        set_b(1'b1, 1'b0, '0, '0);
        @(negedge clk);
        chk1("pin_b_gnt", b_gnt, 1'b1);
        next_cycle();

        // Continuous contention: A reads @1, B writes 0x3FF@5.
        set_a(1'b1, 1'b0, 10'd1, '0);
        set_b(1'b1, 1'b1, 10'd5, 10'h3FF);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk1("pin_rr_a", a_gnt, FIXED || (i % 2 == 0));
            chk1("pin_rr_b", b_gnt, !FIXED && (i % 2 == 1));
            if (i >= 2 && (FIXED || i % 2 == 0)) begin
                chk1("pin_rr_rv", a_rvalid, 1'b1);
                chk10("pin_rr_rd", a_rdata, 10'h002);
            end
            next_cycle();
        end
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
        repeat (2) next_cycle();

        // Read-after-write across ports.
        set_b(1'b1, 1'b1, 10'd1, 10'h004);
        @(negedge clk);
        chk1("pin_raw_bg", b_gnt, 1'b1);
        next_cycle();
        set_b(1'b0, 1'b0, '0, '0);
        set_a(1'b1, 1'b0, 10'd1, '0);
        @(negedge clk);
        chk1("pin_raw_ag", a_gnt, 1'b1);
        next_cycle();
        set_a(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk1("pin_raw_nob", b_rvalid, 1'b0);
        next_cycle();
        @(negedge clk);
        chk1("pin_raw_v", a_rvalid, 1'b1);
        chk10("pin_raw_d", a_rdata, 10'h004);
        next_cycle();

        // Reset right after a read grant discards the response.
        set_a(1'b1, 1'b0, 10'd2, '0);
        @(negedge clk);
        chk1("pin_mr_g", a_gnt, 1'b1);
        next_cycle();
        rst_n = 1'b0;
        set_a(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk1("pin_mr_rv0", a_rvalid, 1'b0);
        chk10("pin_mr_rd0", a_rdata, 10'h000);
        next_cycle();
        @(negedge clk);
        chk1("pin_mr_rv1", a_rvalid, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk1("pin_mr_rv2", a_rvalid, 1'b0);
        next_cycle();
        set_a(1'b1, 1'b0, 10'd2, '0);
        next_cycle();
        set_a(1'b0, 1'b0, '0, '0);
        next_cycle();
        @(negedge clk);
        chk1("pin_mr_v", a_rvalid, 1'b1);
        chk10("pin_mr_d", a_rdata, 10'h003);
        next_cycle();

`ifdef RAM_ARB_FIXED_PRIO_EN
        set_a(1'b1, 1'b0, 10'd0, '0);
        set_b(1'b1, 1'b0, 10'd1, '0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk1("pin_fp_a", a_gnt, 1'b1);
            chk1("pin_fp_b", b_gnt, 1'b0);
            next_cycle();
        end
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
        next_cycle();
`endif

        // Random traffic with occasional resets; each port holds until granted.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ga = a_gnt;
            gb = b_gnt;
            @(posedge clk);
            #1;
            rst_n = ($urandom_range(0, 299) != 0);
            if (ga || !a_req)
                set_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
            if (gb || !b_req)
                set_b($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
        end
        rst_n = 1'b1;
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
        repeat (4) next_cycle();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
